// File: rtl/branch_recovery_unit.sv
// branch_recovery_unit
//   Tracks conditional branches from decode until memory-stage resolution.
//   On a direction mispredict it drives a one-cycle fetch redirect and holds
//   the pipeline flush line for FLUSH_CYCLES cycles. Younger in-flight records
//   are wrong-path, so they are discarded at that point.
//
//   Optional build macro: BRU_STATS_EN enables the saturating statistics
//   counters. Without it, branch_count and mispredict_count are tied to 0.
//
// Ports
//   clk, reset         : clock, asynchronous active-high reset
//   dec_valid          : branch in decode this cycle
//   dec_pc/dec_target  : branch PC and taken target
//   dec_prediction     : predicted taken
//   stall              : pipeline hold (blocks pushes only)
//   mem_resolve        : oldest tracked branch resolves this cycle
//   mem_taken          : actual branch outcome
//   redirect_valid/_pc : one-cycle PC redirect and corrected address
//   flush              : squash IF/ID/EX pipeline registers
//   busy               : records in flight or recovery in progress
//   overflow_err       : sticky, push dropped while full
//   underflow_err      : sticky, resolve seen while empty
//   branch_count       : resolved branches (BRU_STATS_EN)
//   mispredict_count   : mispredicted branches (BRU_STATS_EN)
module branch_recovery_unit #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [31:0]      dec_pc,
    input  logic [31:0]      dec_target,
    input  logic             dec_prediction,
    input  logic             stall,
    input  logic             mem_resolve,
    input  logic             mem_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic             busy,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [2:0]    FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic {
        TRACK   = 1'b0,
        RECOVER = 1'b1
    } state_t;

    // Record storage
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] tgt_mem  [DEPTH];
    logic        pred_mem [DEPTH];

    state_t      state_q, state_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        flush_q, flush_d;
    logic        busy_q, busy_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    logic in_track, empty, full;
    logic pop, mispred, good_pop, push_req, push, drop, underflow;

    always_comb begin
        in_track  = (state_q == TRACK);
        empty     = (cnt_q == '0);
        full      = (cnt_q == FULL_CNT);
        pop       = in_track & mem_resolve & ~empty;
        mispred   = pop & (pred_mem[rd_q] != mem_taken);
        good_pop  = pop & ~mispred;
        push_req  = in_track & dec_valid & ~stall;
        // A correct pop in the same cycle frees the head slot, so a push
        // into a full buffer is accepted then and occupancy is unchanged.
        push      = push_req & ~mispred & (~full | good_pop);
        drop      = push_req & full & ~pop;
        underflow = in_track & mem_resolve & empty;
    end

    always_comb begin
        state_d          = state_q;
        fcnt_d           = fcnt_q;
        wr_d             = wr_q;
        rd_d             = rd_q;
        cnt_d            = cnt_q;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = redirect_pc_q;
        ovf_d            = ovf_q | drop;
        unf_d            = unf_q | underflow;

        unique case (state_q)
            TRACK: begin
                if (mispred) begin
                    // Everything younger than the mispredicted branch is
                    // wrong-path: empty the buffer on the same edge.
                    state_d          = RECOVER;
                    fcnt_d           = FLUSH_LOAD;
                    wr_d             = '0;
                    rd_d             = '0;
                    cnt_d            = '0;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = mem_taken ? tgt_mem[rd_q]
                                                 : pc_mem[rd_q] + 32'd4;
                end else begin
                    if (push) wr_d = wr_q + PTR_ONE;
                    if (pop)  rd_d = rd_q + PTR_ONE;
                    unique case ({push, pop})
                        2'b10:   cnt_d = cnt_q + CNT_ONE;
                        2'b01:   cnt_d = cnt_q - CNT_ONE;
                        default: cnt_d = cnt_q;
                    endcase
                end
            end
            RECOVER: begin
                if (fcnt_q == '0) state_d = TRACK;
                else              fcnt_d  = fcnt_q - 3'd1;
            end
            default: state_d = TRACK;
        endcase

        flush_d = (state_d == RECOVER);
        busy_d  = (cnt_d != '0) | (state_d == RECOVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= TRACK;
            fcnt_q           <= '0;
            wr_q             <= '0;
            rd_q             <= '0;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_q          <= 1'b0;
            busy_q           <= 1'b0;
            ovf_q            <= 1'b0;
            unf_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            fcnt_q           <= fcnt_d;
            wr_q             <= wr_d;
            rd_q             <= rd_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            busy_q           <= busy_d;
            ovf_q            <= ovf_d;
            unf_q            <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]   <= dec_pc;
            tgt_mem[wr_q]  <= dec_target;
            pred_mem[wr_q] <= dec_prediction;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;
    assign busy           = busy_q;
    assign overflow_err   = ovf_q;
    assign underflow_err  = unf_q;

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] branch_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (pop && branch_cnt_q != '1)
                branch_cnt_q <= branch_cnt_q + CNT_W'(1);
            if (mispred && mispred_cnt_q != '1)
                mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_recovery_unit.sv
// Testbench for branch_recovery_unit: directed vector table, reset during
// recovery, and randomized traffic against a queue-based reference model.
module tb_branch_recovery_unit;

    localparam int unsigned DEPTH        = 4;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned CNT_W        = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             dec_valid = 1'b0;
    logic [31:0]      dec_pc = '0;
    logic [31:0]      dec_target = '0;
    logic             dec_prediction = 1'b0;
    logic             stall = 1'b0;
    logic             mem_resolve = 1'b0;
    logic             mem_taken = 1'b0;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic             flush;
    logic             busy;
    logic             overflow_err;
    logic             underflow_err;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    branch_recovery_unit #(
        .DEPTH(DEPTH),
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .dec_valid(dec_valid),
        .dec_pc(dec_pc),
        .dec_target(dec_target),
        .dec_prediction(dec_prediction),
        .stall(stall),
        .mem_resolve(mem_resolve),
        .mem_taken(mem_taken),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .flush(flush),
        .busy(busy),
        .overflow_err(overflow_err),
        .underflow_err(underflow_err),
        .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
    } rec_t;

    rec_t        mq[$];
    int          rec_left;
    logic        m_rv;
    logic [31:0] m_rpc;
    logic        m_ovf, m_unf;
    longint      m_bc, m_mc;
    longint      sat_max = (longint'(1) << CNT_W) - 1;

    task automatic model_reset();
        mq.delete();
        rec_left = 0;
        m_rv = 0; m_rpc = '0; m_ovf = 0; m_unf = 0; m_bc = 0; m_mc = 0;
    endtask

    // Applies one clock edge worth of behaviour using the current inputs.
    task automatic model_step();
        bit   mis;
        rec_t r;
        mis  = 0;
        m_rv = 0;
        if (rec_left > 0) begin
            rec_left--;
        end else begin
            if (mem_resolve) begin
                if (mq.size() == 0) begin
                    m_unf = 1;
                end else begin
                    r = mq.pop_front();
                    if (m_bc < sat_max) m_bc++;
                    if (r.pred != mem_taken) begin
                        mis = 1;
                        mq.delete();
                        if (m_mc < sat_max) m_mc++;
                        m_rv     = 1;
                        m_rpc    = mem_taken ? r.tgt : r.pc + 32'd4;
                        rec_left = FLUSH_CYCLES;
                    end
                end
            end
            if (dec_valid && !stall && !mis) begin
                if (mq.size() < DEPTH) begin
                    r.pc = dec_pc; r.tgt = dec_target; r.pred = dec_prediction;
                    mq.push_back(r);
                end else begin
                    m_ovf = 1;
                end
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic chk_counters();
        chk("branch_count",     32'(branch_count),     STATS ? 32'(m_bc) : 32'd0);
        chk("mispredict_count", 32'(mispredict_count), STATS ? 32'(m_mc) : 32'd0);
    endtask

    task automatic chk_model();
        chk("m_redirect_valid", 32'(redirect_valid), 32'(m_rv));
        chk("m_redirect_pc",    redirect_pc,         m_rpc);
        chk("m_flush",          32'(flush),          32'(rec_left > 0));
        chk("m_busy",           32'(busy),           32'((mq.size() > 0) || (rec_left > 0)));
        chk("m_overflow_err",   32'(overflow_err),   32'(m_ovf));
        chk("m_underflow_err",  32'(underflow_err),  32'(m_unf));
        chk_counters();
    endtask

    task automatic cycle(input logic dv, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred, input logic st, input logic res, input logic tk);
        dec_valid = dv; dec_pc = pc; dec_target = tgt; dec_prediction = pred;
        stall = st; mem_resolve = res; mem_taken = tk;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        dv;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred, st, res, tk;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_fl, e_busy, e_ovf, e_unf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic dv, input logic [31:0] pc, input logic [31:0] tgt,
                       input logic pred, input logic st, input logic res, input logic tk,
                       input logic e_rv, input logic [31:0] e_rpc, input logic e_fl,
                       input logic e_busy, input logic e_ovf, input logic e_unf);
        vec_t v;
        v.dv = dv; v.pc = pc; v.tgt = tgt; v.pred = pred; v.st = st; v.res = res; v.tk = tk;
        v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_fl = e_fl; v.e_busy = e_busy;
        v.e_ovf = e_ovf; v.e_unf = e_unf;
        vecs.push_back(v);
    endtask

    initial begin
        //   dv pc            tgt           pr st rs tk   rv rpc           fl bz ov un
        // correct-taken branch
        add(1, 32'h100,      32'h140,      1, 0, 0, 0,   0, 32'h0,        0, 1, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 1, 1,   0, 32'h0,        0, 0, 0, 0);
        // predicted-not-taken mispredict
        add(1, 32'h200,      32'h180,      0, 0, 0, 0,   0, 32'h0,        0, 1, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 1, 1,   1, 32'h180,      1, 1, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,   0, 32'h180,      1, 1, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,   0, 32'h180,      0, 0, 0, 0);
        // predicted-taken mispredict, fall-through wraps to 0
        add(1, 32'hFFFFFFFC, 32'h40,       1, 0, 0, 0,   0, 32'h180,      0, 1, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 1, 0,   1, 32'h0,        1, 1, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,   0, 32'h0,        1, 1, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,   0, 32'h0,        0, 0, 0, 0);
        // wrong-path squash, resolves during recovery ignored, then underflow
        add(1, 32'h300,      32'h380,      1, 0, 0, 0,   0, 32'h0,        0, 1, 0, 0);
        add(1, 32'h304,      32'h390,      0, 0, 0, 0,   0, 32'h0,        0, 1, 0, 0);
        add(1, 32'h308,      32'h3A0,      1, 0, 0, 0,   0, 32'h0,        0, 1, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 1, 0,   1, 32'h304,      1, 1, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 1, 1,   0, 32'h304,      1, 1, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 1, 0,   0, 32'h304,      0, 0, 0, 0);
        add(0, 32'h0,        32'h0,        0, 0, 1, 1,   0, 32'h304,      0, 0, 0, 1);
        // overflow, then push + correct pop at full
        add(1, 32'h400,      32'h500,      1, 0, 0, 0,   0, 32'h304,      0, 1, 0, 1);
        add(1, 32'h404,      32'h504,      1, 0, 0, 0,   0, 32'h304,      0, 1, 0, 1);
        add(1, 32'h408,      32'h508,      1, 0, 0, 0,   0, 32'h304,      0, 1, 0, 1);
        add(1, 32'h40C,      32'h50C,      1, 0, 0, 0,   0, 32'h304,      0, 1, 0, 1);
        add(1, 32'h410,      32'h510,      1, 0, 0, 0,   0, 32'h304,      0, 1, 1, 1);
        add(1, 32'h414,      32'h514,      0, 0, 1, 1,   0, 32'h304,      0, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 1, 1,   0, 32'h304,      0, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 1, 1,   0, 32'h304,      0, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 1, 1,   0, 32'h304,      0, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 1, 1,   1, 32'h514,      1, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,   0, 32'h514,      1, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,   0, 32'h514,      0, 0, 1, 1);
        // stall blocks push but not resolve
        add(1, 32'h600,      32'h640,      1, 1, 0, 0,   0, 32'h514,      0, 0, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 1, 1,   0, 32'h514,      0, 0, 1, 1);
        add(1, 32'h700,      32'h7F0,      1, 0, 0, 0,   0, 32'h514,      0, 1, 1, 1);
        add(1, 32'h704,      32'h7F4,      1, 1, 1, 1,   0, 32'h514,      0, 0, 1, 1);
        // push discarded by a simultaneous mispredicting pop
        add(1, 32'h800,      32'h880,      0, 0, 0, 0,   0, 32'h514,      0, 1, 1, 1);
        add(1, 32'h804,      32'h884,      1, 0, 1, 1,   1, 32'h880,      1, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,   0, 32'h880,      1, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,   0, 32'h880,      0, 0, 1, 1);
        // next mispredict right after recovery
        add(1, 32'h900,      32'h990,      0, 0, 0, 0,   0, 32'h880,      0, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 1, 1,   1, 32'h990,      1, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,   0, 32'h990,      1, 1, 1, 1);
        add(0, 32'h0,        32'h0,        0, 0, 0, 0,   0, 32'h990,      0, 0, 1, 1);

        // ---------------- reset ----------------
        model_reset();
        #2 reset = 1'b1;
        #2;
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc",    redirect_pc,         32'd0);
        chk("rst_flush",          32'(flush),          32'd0);
        chk("rst_busy",           32'(busy),           32'd0);
        chk("rst_overflow_err",   32'(overflow_err),   32'd0);
        chk("rst_underflow_err",  32'(underflow_err),  32'd0);
        chk("rst_branch_count",   32'(branch_count),   32'd0);
        chk("rst_mispred_count",  32'(mispredict_count), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].dv, vecs[i].pc, vecs[i].tgt, vecs[i].pred,
                  vecs[i].st, vecs[i].res, vecs[i].tk);
            chk($sformatf("v%0d_redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].e_rv));
            chk($sformatf("v%0d_redirect_pc", i),    redirect_pc,         vecs[i].e_rpc);
            chk($sformatf("v%0d_flush", i),          32'(flush),          32'(vecs[i].e_fl));
            chk($sformatf("v%0d_busy", i),           32'(busy),           32'(vecs[i].e_busy));
            chk($sformatf("v%0d_overflow_err", i),   32'(overflow_err),   32'(vecs[i].e_ovf));
            chk($sformatf("v%0d_underflow_err", i),  32'(underflow_err),  32'(vecs[i].e_unf));
            chk_counters();
        end

        // ---------------- reset during recovery ----------------
        cycle(1, 32'hA00, 32'hAA0, 0, 0, 0, 0);
        cycle(0, 32'h0, 32'h0, 0, 0, 1, 1);
        chk("mid_pre_flush", 32'(flush), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_flush",          32'(flush),          32'd0);
        chk("mid_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("mid_redirect_pc",    redirect_pc,         32'd0);
        chk("mid_busy",           32'(busy),           32'd0);
        chk("mid_overflow_err",   32'(overflow_err),   32'd0);
        chk("mid_underflow_err",  32'(underflow_err),  32'd0);
        chk("mid_branch_count",   32'(branch_count),   32'd0);
        chk("mid_mispred_count",  32'(mispredict_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        // FSM must be back in TRACK: an immediate mispredict is accepted
        cycle(1, 32'hB00, 32'hBB0, 0, 0, 0, 0);
        chk_model();
        cycle(0, 32'h0, 32'h0, 0, 0, 1, 1);
        chk("post_rst_redirect_valid", 32'(redirect_valid), 32'd1);
        chk("post_rst_redirect_pc",    redirect_pc,         32'hBB0);
        chk_model();

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 3000; n++) begin
            logic        dv, st, res, tk, pr;
            logic [31:0] pc, tgt;
            dv  = ($urandom_range(99) < 55);
            st  = ($urandom_range(99) < 20);
            res = ($urandom_range(99) < 35);
            tk  = 1'($urandom);
            pr  = ($urandom_range(99) < 75) ? tk ^ 1'($urandom_range(99) < 15) : 1'($urandom);
            pc  = ($urandom_range(31) == 0) ? 32'hFFFFFFFC : {$urandom, 2'b00} >> 2 << 2;
            tgt = $urandom;
            cycle(dv, pc, tgt, pr, st, res, tk);
            chk_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
